// File: rtl/cxs_bridge_pkg.sv
// Shared definitions for the CXS bridge TX path: scheduler states, link credit limit
// and error flag bit positions.
package cxs_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_REQ    = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_SEND      = 2'd3
    } sched_state_t;

    localparam int CXS_MAX_CREDIT = 15;

    localparam int ERR_CREDIT_OVF  = 0;
    localparam int ERR_OWN_SENDING = 1;

endpackage

// File: rtl/cxs_credit_ctr.sv
// CXS TX link credit counter: counts receiver grants, spends one per flit, saturates
// at the link maximum and flushes whenever the link leaves RUN.
module cxs_credit_ctr #(
    parameter int MAX_CREDIT = 15,
    parameter int CRED_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              link_up,
    input  logic              credit_ret,
    input  logic              flit_valid,
    output logic [CRED_W-1:0] credit_cnt,
    output logic              overflow
);

    localparam logic [CRED_W-1:0] MAX_CNT = CRED_W'(MAX_CREDIT);

    // A grant and a spend in the same cycle cancel; a grant at the ceiling is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            credit_cnt <= '0;
            overflow   <= 1'b0;
        end else if (!link_up) begin
            credit_cnt <= '0;
        end else if (credit_ret && !flit_valid) begin
            if (credit_cnt == MAX_CNT) begin
                overflow <= 1'b1;
            end else begin
                credit_cnt <= credit_cnt + CRED_W'(1);
            end
        end else if (flit_valid && !credit_ret && credit_cnt != '0) begin
            credit_cnt <= credit_cnt - CRED_W'(1);
        end
    end

endmodule

// File: rtl/cxs_txflit_sched.sv
// CXS TX flit scheduler: walks host-owned TX buffer slots in strict ring order, reads each
// flit, presents it on the link when a credit is held and hands the slot back afterwards.
module cxs_txflit_sched
    import cxs_bridge_pkg::*;
#(
    parameter int NUM_SLOTS  = 15,
    parameter int ADDR_W     = 4,
    parameter int MAX_CREDIT = CXS_MAX_CREDIT,
    parameter int CRED_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SLOTS-1:0] own_set,
    input  logic                 credit_ret,
    input  logic                 link_up,
    output logic                 rd_req,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic                 rd_vld,
    output logic                 flit_valid,
    output logic                 flit_pending,
    output logic [NUM_SLOTS-1:0] ownership,
    output logic [CRED_W-1:0]    credit_cnt,
    output logic [1:0]           err_sticky
);

    sched_state_t          state, state_nxt;
    logic [ADDR_W-1:0]     ptr, ptr_nxt, rd_addr_nxt;
    logic                  rd_req_nxt, flit_valid_nxt, flit_pending_nxt;
    logic [NUM_SLOTS-1:0]  clr_mask;
    logic                  credit_ok, go, own_err, credit_ovf;

    cxs_credit_ctr #(
        .MAX_CREDIT (MAX_CREDIT),
        .CRED_W     (CRED_W)
    ) u_credit (
        .clk        (clk),
        .rst_n      (rst_n),
        .link_up    (link_up),
        .credit_ret (credit_ret),
        .flit_valid (flit_valid),
        .credit_cnt (credit_cnt),
        .overflow   (credit_ovf)
    );

    assign credit_ok = link_up && (credit_cnt != '0);
    assign go        = ownership[ptr] && credit_ok;
    assign clr_mask  = NUM_SLOTS'(flit_valid) << rd_addr;

    // The slot just sent goes back to the host even if the host re-hands it in that cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ownership <= '0;
            own_err   <= 1'b0;
        end else begin
            ownership <= (ownership | own_set) & ~clr_mask;
            if (|(own_set & clr_mask)) begin
                own_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            rd_req       <= 1'b0;
            rd_addr      <= '0;
            flit_valid   <= 1'b0;
            flit_pending <= 1'b0;
        end else begin
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            rd_req       <= rd_req_nxt;
            rd_addr      <= rd_addr_nxt;
            flit_valid   <= flit_valid_nxt;
            flit_pending <= flit_pending_nxt;
        end
    end

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    always_comb begin
        state_nxt        = state;
        ptr_nxt          = ptr;
        rd_addr_nxt      = rd_addr;
        rd_req_nxt       = 1'b0;
        flit_valid_nxt   = 1'b0;
        flit_pending_nxt = flit_pending;
        case (state)
            ST_IDLE: begin
                flit_pending_nxt = 1'b0;
                if (go) begin
                    state_nxt        = ST_RD_REQ;
                    rd_req_nxt       = 1'b1;
                    rd_addr_nxt      = ptr;
                    flit_pending_nxt = 1'b1;
                end
            end
            ST_RD_REQ: begin
                state_nxt = ST_WAIT_DATA;
            end
            ST_WAIT_DATA: begin
                if (rd_vld) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (credit_ok) begin
                    flit_valid_nxt = 1'b1;
                    state_nxt      = ST_IDLE;
                    ptr_nxt        = (ptr == ADDR_W'(NUM_SLOTS - 1)) ? '0 : ptr + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign err_sticky[ERR_CREDIT_OVF]  = credit_ovf;
    assign err_sticky[ERR_OWN_SENDING] = own_err;

endmodule
